// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-boundary types: stage register state, per-boundary payload
// structs, their widths (used as DATA_W) and their NOP bubble encodings.
package pipe_stage_reg_pkg;

    // Stage register occupancy state; encodings equal the held beat count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pstage_state_t;

    // Instruction class carried down the pipe; RTYPE is the all-zero encoding.
    typedef enum logic [1:0] {
        RTYPE = 2'd0,
        ITYPE = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } op_class_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        op_class_t   op;
        logic [4:0]  rd;
        logic        reg_we;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        op_class_t   op;
        logic [4:0]  rd;
        logic        reg_we;
        logic [31:0] alu_res;
        logic [31:0] store_val;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_we;
        logic [31:0] wb_val;
    } mem_wb_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

    // Bubbles: RTYPE with no register write, so a bubble never retires a result.
    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'd0, instr: 32'd0};
    localparam id_ex_t ID_EX_BUBBLE = '{op: RTYPE, rd: 5'd0, reg_we: 1'b0,
                                        rs1_val: 32'd0, rs2_val: 32'd0, imm: 32'd0};
    localparam ex_mem_t EX_MEM_BUBBLE = '{op: RTYPE, rd: 5'd0, reg_we: 1'b0,
                                          alu_res: 32'd0, store_val: 32'd0};
    localparam mem_wb_t MEM_WB_BUBBLE = '{rd: 5'd0, reg_we: 1'b0, wb_val: 32'd0};

    // Number of beats held in a given state.
    function automatic logic [1:0] pstage_occ(input pstage_state_t s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream carrying one flattened pipeline payload.
//   valid : beat present (driven by master)
//   data  : payload (driven by master)
//   ready : consumer accepts the beat (driven by slave)
interface pipe_stage_reg_if
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = IF_ID_W
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with valid/ready handshake, optional skid entry,
// flush-to-bubble, occupancy and a saturating stall counter.
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   flush      : drop every held beat and the beat offered this cycle
//   up         : upstream stream (slave); up.ready is registered when SKID=1
//   dn         : downstream stream (master); dn.data is BUBBLE when not valid
//   occupancy  : beats currently held (0..2)
//   stall_cnt  : saturating count of cycles with dn.valid & ~dn.ready
//   stall_clr  : synchronous clear of stall_cnt, wins over increment
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W = IF_ID_W,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter bit                SKID   = 1'b1,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    pipe_stage_reg_if.slave  up,
    pipe_stage_reg_if.master dn,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    pstage_state_t     state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              rdy_q;
    logic [CNT_W-1:0]  stall_q;

    logic held_c;
    logic accept_c;
    logic drain_c;
    logic stall_c;

    assign held_c   = (state_q != EMPTY);
    // SKID=1: ready comes from a flop; SKID=0: classic pass-through ready.
    assign up.ready = ~RST & (SKID ? rdy_q : (dn.ready | ~held_c));
    assign accept_c = up.valid & up.ready;
    assign drain_c  = held_c & dn.ready;
    assign stall_c  = held_c & ~dn.ready & ~flush;

    // Main register feeds the output directly; it holds BUBBLE whenever empty.
    assign dn.valid  = held_c;
    assign dn.data   = main_q;
    assign occupancy = pstage_occ(state_q);
    assign stall_cnt = stall_q;

    // Stall counter: clear beats increment, saturates at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
        end else if (stall_clr) begin
            stall_q <= '0;
        end else if (stall_c && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    // Occupancy FSM and payload entries; flush overrides every transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            rdy_q   <= 1'b1;
        end else if (flush) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            rdy_q   <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        state_q <= ONE;
                        main_q  <= up.data;
                    end
                end
                ONE: begin
                    if (accept_c && drain_c) begin
                        main_q <= up.data;
                    end else if (accept_c) begin
                        // Only reachable with SKID=1; SKID=0 never accepts
                        // into ONE without a simultaneous drain.
                        if (SKID) begin
                            state_q <= FULL;
                            skid_q  <= up.data;
                            rdy_q   <= 1'b0;
                        end
                    end else if (drain_c) begin
                        state_q <= EMPTY;
                        main_q  <= BUBBLE;
                    end
                end
                FULL: begin
                    if (drain_c) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                        skid_q  <= BUBBLE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    main_q  <= BUBBLE;
                    skid_q  <= BUBBLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1/CNT_W=4 instance with a non-zero bubble
// and a SKID=0/CNT_W=16 instance share one stimulus stream; both are compared
// every cycle against a beat-queue model of the stage.
module tb_pipe_stage_reg;

    localparam int unsigned DW    = 64;
    localparam logic [DW-1:0] BUB_A = 64'hDEAD_BEEF_0000_0001;
    localparam logic [DW-1:0] BUB_B = '0;
    localparam int unsigned CW_A  = 4;
    localparam int unsigned CW_B  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;
    logic          stall_clr;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic [1:0]      occ_a;
    logic [1:0]      occ_b;
    logic [CW_A-1:0] stall_a;
    logic [CW_B-1:0] stall_b;

    pipe_stage_reg_if #(.DATA_W(DW)) up_a ();
    pipe_stage_reg_if #(.DATA_W(DW)) dn_a ();
    pipe_stage_reg_if #(.DATA_W(DW)) up_b ();
    pipe_stage_reg_if #(.DATA_W(DW)) dn_b ();

    assign up_a.valid = in_valid;
    assign up_a.data  = in_data;
    assign dn_a.ready = out_ready;
    assign up_b.valid = in_valid;
    assign up_b.data  = in_data;
    assign dn_b.ready = out_ready;

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE(BUB_A), .SKID(1'b1), .CNT_W(CW_A)) dut_a (
        .CLK(clk), .RST(rst), .flush(flush), .up(up_a), .dn(dn_a),
        .occupancy(occ_a), .stall_cnt(stall_a), .stall_clr(stall_clr)
    );

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE(BUB_B), .SKID(1'b0), .CNT_W(CW_B)) dut_b (
        .CLK(clk), .RST(rst), .flush(flush), .up(up_b), .dn(dn_b),
        .occupancy(occ_b), .stall_cnt(stall_b), .stall_clr(stall_clr)
    );

    // Reference model: per instance, an ordered list of held beats plus a counter.
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          occ  [2];
    logic [63:0] ent  [2][2];
    int          scnt [2];
    int          cap  [2];
    int          smax [2];
    logic [63:0] bub  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready(input int i);
        if (rst) return 1'b0;
        if (cap[i] == 2) return occ[i] < 2;
        return out_ready || (occ[i] == 0);
    endfunction

    function automatic logic [63:0] exp_data(input int i);
        return (occ[i] > 0) ? ent[i][0] : bub[i];
    endfunction

    task automatic check_all();
        chk("a.in_ready",  64'(up_a.ready), 64'(exp_ready(0)));
        chk("a.out_valid", 64'(dn_a.valid), 64'(occ[0] > 0));
        chk("a.out_data",  dn_a.data,       exp_data(0));
        chk("a.occupancy", 64'(occ_a),      64'(occ[0]));
        chk("a.stall_cnt", 64'(stall_a),    64'(scnt[0]));
        chk("b.in_ready",  64'(up_b.ready), 64'(exp_ready(1)));
        chk("b.out_valid", 64'(dn_b.valid), 64'(occ[1] > 0));
        chk("b.out_data",  dn_b.data,       exp_data(1));
        chk("b.occupancy", 64'(occ_b),      64'(occ[1]));
        chk("b.stall_cnt", 64'(stall_b),    64'(scnt[1]));
    endtask

    // One clock: check settled outputs, then advance the model across the edge.
    task automatic tick();
        bit acc [2];
        bit drn [2];
        bit stl [2];
        #1;
        check_all();
        for (int i = 0; i < 2; i++) begin
            acc[i] = in_valid && exp_ready(i);
            drn[i] = (occ[i] > 0) && out_ready;
            stl[i] = (occ[i] > 0) && !out_ready && !flush;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                occ[i]  = 0;
                scnt[i] = 0;
            end else begin
                if (stall_clr)                          scnt[i] = 0;
                else if (stl[i] && (scnt[i] < smax[i])) scnt[i] = scnt[i] + 1;
                if (flush) begin
                    occ[i] = 0;
                end else begin
                    if (drn[i]) begin
                        ent[i][0] = ent[i][1];
                        occ[i]    = occ[i] - 1;
                    end
                    if (acc[i]) begin
                        ent[i][occ[i]] = in_data;
                        occ[i]         = occ[i] + 1;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        cap  = '{2, 1};
        smax = '{15, 65535};
        bub  = '{BUB_A, BUB_B};
        occ  = '{0, 0};
        scnt = '{0, 0};
        rst = 1'b1; flush = 1'b0; stall_clr = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset held for two edges; first edge only initialises the design.
        @(posedge clk);
        @(negedge clk);
        tick();
        chk("rst.in_ready_a", 64'(up_a.ready), 64'd0);
        chk("rst.in_ready_b", 64'(up_b.ready), 64'd0);
        rst = 1'b0;

        // Streaming at full rate.
        in_valid = 1'b1; out_ready = 1'b1;
        in_data = 64'hA; tick();
        chk("stream.a0", dn_a.data, 64'hA);
        chk("stream.occ0", 64'(occ_a), 64'd1);
        in_data = 64'hB; tick();
        chk("stream.a1", dn_a.data, 64'hB);
        in_data = 64'hC; tick();
        chk("stream.a2", dn_a.data, 64'hC);
        chk("stream.b2", dn_b.data, 64'hC);
        in_valid = 1'b0; tick();
        chk("stream.empty", 64'(occ_a), 64'd0);

        // Backpressure fills main then skid; third beat waits.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 64'h11; tick();
        chk("bp.occ1", 64'(occ_a), 64'd1);
        in_data = 64'h22; tick();
        chk("bp.occ2", 64'(occ_a), 64'd2);
        chk("bp.not_ready", 64'(up_a.ready), 64'd0);
        in_data = 64'h33; tick(); tick();
        chk("bp.stall_a", 64'(stall_a), 64'd3);
        chk("bp.stall_b", 64'(stall_b), 64'd3);
        chk("bp.head", dn_a.data, 64'h11);
        out_ready = 1'b1; tick();
        chk("bp.order1", dn_a.data, 64'h22);
        tick();
        chk("bp.order2", dn_a.data, 64'h33);
        in_valid = 1'b0; tick();
        chk("bp.drained", 64'(occ_a), 64'd0);

        // Flush while full with a beat offered.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 64'h12; tick();
        in_data = 64'h13; tick();
        chk("fl.full", 64'(occ_a), 64'd2);
        flush = 1'b1; in_data = 64'h44; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl.occ", 64'(occ_a), 64'd0);
        chk("fl.valid", 64'(dn_a.valid), 64'd0);
        chk("fl.bubble", dn_a.data, BUB_A);
        chk("fl.stall_a", 64'(stall_a), 64'd4);
        chk("fl.stall_b", 64'(stall_b), 64'd4);
        out_ready = 1'b1; tick(); tick();

        // Accept and drain in the same cycle; SKID=0 ready follows out_ready.
        in_valid = 1'b1;
        in_data = 64'h55; tick();
        in_data = 64'h66; tick();
        chk("ad.a_data", dn_a.data, 64'h66);
        chk("ad.a_occ", 64'(occ_a), 64'd1);
        chk("ad.b_data", dn_b.data, 64'h66);
        chk("ad.b_occ", 64'(occ_b), 64'd1);
        in_valid = 1'b0;
        out_ready = 1'b0; #1;
        chk("ad.b_ready_lo", 64'(up_b.ready), 64'd0);
        out_ready = 1'b1; #1;
        chk("ad.b_ready_hi", 64'(up_b.ready), 64'd1);
        chk("ad.a_ready", 64'(up_a.ready), 64'd1);
        tick();

        // Stall counter saturation and clear priority.
        stall_clr = 1'b1; tick();
        stall_clr = 1'b0;
        in_valid = 1'b1; in_data = 64'h99; out_ready = 1'b0; tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("sat.a", 64'(stall_a), 64'd15);
        chk("sat.b", 64'(stall_b), 64'd20);
        stall_clr = 1'b1; tick();
        stall_clr = 1'b0;
        chk("clr.a", 64'(stall_a), 64'd0);
        chk("clr.b", 64'(stall_b), 64'd0);

        // Reset while full: held beats never appear.
        flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b1;
        in_data = 64'h77; tick();
        in_data = 64'h88; tick();
        chk("rs.full", 64'(occ_a), 64'd2);
        chk("rs.head", dn_a.data, 64'h77);
        in_valid = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        chk("rs.occ", 64'(occ_a), 64'd0);
        chk("rs.bubble", dn_a.data, BUB_A);
        chk("rs.valid", 64'(dn_a.valid), 64'd0);
        out_ready = 1'b1;
        repeat (3) tick();

        // Randomised traffic with occasional flush, clear and reset.
        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            stall_clr = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; stall_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
